// File: rtl/alu_seq.sv
// Four-cycle instruction sequencer around an 8x16 register file, driving an external combinational ALU.
// Optional host read port enabled by defining ALU_SEQ_RDPORT_EN.
module alu_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [15:0] wr_data,
  output logic [2:0]  alu_op,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  input  logic [15:0] alu_out,
  input  logic        alu_zerof,
  output logic [15:0] result,
  output logic        zero,
  output logic        done,
  output logic [1:0]  dbg_state
`ifdef ALU_SEQ_RDPORT_EN
  ,
  input  logic [2:0]  rd_addr,
  output logic [15:0] rd_data
`endif
);

  // Handshake: an instruction transfers on a rising clk edge where
  // instr_valid and instr_ready are both high; instr_ready is high only in IDLE.
  typedef enum logic [1:0] {IDLE = 2'd0, OPER = 2'd1, EXEC = 2'd2, WB = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [15:0] regs [8];
  logic [15:0] instr_q;
  logic        accept;

  assign accept    = instr_valid && instr_ready;
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = OPER;
      end
      OPER:    state_d = EXEC;
      EXEC:    state_d = WB;
      WB: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A host write in the accept cycle commits first, so OPER sees the new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      instr_q <= '0;
      alu_op  <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      result  <= '0;
      zero    <= 1'b0;
    end else begin
      if (accept) instr_q <= instr;
      case (state_q)
        IDLE: if (wr_en) regs[wr_addr] <= wr_data;
        OPER: begin
          alu_op <= instr_q[15:13];
          alu_a  <= regs[instr_q[9:7]];
          alu_b  <= regs[instr_q[6:4]];
        end
        EXEC: begin
          result <= alu_out;
          zero   <= alu_zerof;
        end
        WB:      regs[instr_q[12:10]] <= result;
        default: ;
      endcase
    end
  end

`ifdef ALU_SEQ_RDPORT_EN
  assign rd_data = regs[rd_addr];
`endif

endmodule
